// File: rtl/exc_ctrl_seq_pkg.sv
// Shared constants and types for the exception/stall sequencer.
package exc_ctrl_seq_pkg;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned STALL_W = 6;
    localparam int unsigned CNT_W   = 3;
    localparam int unsigned STAT_W  = 16;

    localparam logic [DATA_W-1:0] ZeroWord = 32'h0000_0000;

    localparam logic [DATA_W-1:0] EXC_NONE    = 32'h0000_0000;
    localparam logic [DATA_W-1:0] EXC_INT     = 32'h0000_0001;
    localparam logic [DATA_W-1:0] EXC_SYSCALL = 32'h0000_0008;
    localparam logic [DATA_W-1:0] EXC_INVINST = 32'h0000_000a;
    localparam logic [DATA_W-1:0] EXC_OV      = 32'h0000_000c;
    localparam logic [DATA_W-1:0] EXC_TRAP    = 32'h0000_000d;
    localparam logic [DATA_W-1:0] EXC_ERET    = 32'h0000_000e;

    // Stall vector bit order is {wb, mem, ex, id, if, pc}.
    localparam logic [STALL_W-1:0] STALL_NONE = 6'b000000;
    localparam logic [STALL_W-1:0] STALL_ID   = 6'b000111;
    localparam logic [STALL_W-1:0] STALL_EX   = 6'b001111;
    localparam logic [STALL_W-1:0] STALL_ALL  = 6'b111111;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FREEZE = 2'd1,
        ST_FLUSH  = 2'd2,
        ST_HOLD   = 2'd3
    } state_e;

    function automatic logic exc_code_valid(input logic [DATA_W-1:0] code);
        return (code == EXC_INT)     || (code == EXC_SYSCALL) ||
               (code == EXC_INVINST) || (code == EXC_OV)      ||
               (code == EXC_TRAP)    || (code == EXC_ERET);
    endfunction

endpackage

// File: rtl/exc_ctrl_seq_code_filter.sv
// Valid-code check and redirect target select for an incoming MEM-stage exception.
module exc_code_filter
    import exc_ctrl_seq_pkg::*;
#(
    parameter logic [DATA_W-1:0] EXC_VECTOR = 32'h0000_0020
) (
    input  logic [DATA_W-1:0] except_type_i,
    input  logic [DATA_W-1:0] cp0_epc_i,
    output logic              valid_c,
    output logic [DATA_W-1:0] type_c,
    output logic [DATA_W-1:0] target_c
);

    // Unknown nonzero codes collapse to "no exception".
    always_comb begin
        valid_c  = exc_code_valid(except_type_i);
        type_c   = valid_c ? except_type_i : EXC_NONE;
        target_c = (except_type_i == EXC_ERET) ? cp0_epc_i : EXC_VECTOR;
    end

endmodule

// File: rtl/exc_ctrl_seq.sv
// Exception and stall sequencer: accept -> freeze/commit -> flush/redirect -> hold.
// Build option: define EXC_STATS_EN to enable the accepted-exception counter.
module exc_ctrl_seq
    import exc_ctrl_seq_pkg::*;
#(
    parameter logic [DATA_W-1:0] EXC_VECTOR   = 32'h0000_0020,
    parameter int unsigned       FLUSH_CYCLES = 1,
    parameter int unsigned       HOLD_CYCLES  = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [DATA_W-1:0]  except_type_i,
    input  logic [DATA_W-1:0]  except_pc_i,
    input  logic               is_in_delayslot_i,
    input  logic [DATA_W-1:0]  cp0_epc_i,
    input  logic               stallreq_id_i,
    input  logic               stallreq_ex_i,
    output logic [STALL_W-1:0] stall_o,
    output logic               flush_o,
    output logic [DATA_W-1:0]  new_pc_o,
    output logic               new_pc_valid_o,
    output logic [DATA_W-1:0]  cp0_except_type_o,
    output logic [DATA_W-1:0]  cp0_except_pc_o,
    output logic               cp0_delayslot_o,
    output logic               busy_o,
    output logic [STAT_W-1:0]  exc_count_o
);

    state_e             state;
    logic [CNT_W-1:0]   cnt;
    logic [DATA_W-1:0]  lat_target;
    logic               exc_valid;
    logic [DATA_W-1:0]  exc_type;
    logic [DATA_W-1:0]  exc_target;
    logic [STALL_W-1:0] req_stall;
    logic               accept;

    exc_code_filter #(
        .EXC_VECTOR (EXC_VECTOR)
    ) u_filter (
        .except_type_i (except_type_i),
        .cp0_epc_i     (cp0_epc_i),
        .valid_c       (exc_valid),
        .type_c        (exc_type),
        .target_c      (exc_target)
    );

    assign accept = (state == ST_IDLE) && exc_valid;

    // Stall vector: exception wins over ID/EX requests; EX request dominates ID.
    always_comb begin
        req_stall = STALL_NONE;
        if (stallreq_ex_i) begin
            req_stall = STALL_EX;
        end else if (stallreq_id_i) begin
            req_stall = STALL_ID;
        end
        stall_o = STALL_NONE;
        case (state)
            ST_IDLE:   stall_o = exc_valid ? STALL_ALL : req_stall;
            ST_FREEZE: stall_o = STALL_ALL;
            ST_FLUSH:  stall_o = STALL_NONE;
            ST_HOLD:   stall_o = req_stall;
            default:   stall_o = STALL_NONE;
        endcase
    end

    // Sequencer state and registered outputs; CP0 commit and PC valid are single-cycle pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= ST_IDLE;
            cnt               <= '0;
            lat_target        <= ZeroWord;
            flush_o           <= 1'b0;
            new_pc_o          <= ZeroWord;
            new_pc_valid_o    <= 1'b0;
            cp0_except_type_o <= ZeroWord;
            cp0_except_pc_o   <= ZeroWord;
            cp0_delayslot_o   <= 1'b0;
            busy_o            <= 1'b0;
        end else begin
            new_pc_valid_o    <= 1'b0;
            cp0_except_type_o <= ZeroWord;
            case (state)
                ST_IDLE: begin
                    if (exc_valid) begin
                        state             <= ST_FREEZE;
                        busy_o            <= 1'b1;
                        lat_target        <= exc_target;
                        cp0_except_type_o <= exc_type;
                        cp0_except_pc_o   <= except_pc_i;
                        cp0_delayslot_o   <= is_in_delayslot_i;
                    end
                end
                ST_FREEZE: begin
                    state          <= ST_FLUSH;
                    flush_o        <= 1'b1;
                    new_pc_o       <= lat_target;
                    new_pc_valid_o <= 1'b1;
                    cnt            <= CNT_W'(FLUSH_CYCLES - 1);
                end
                ST_FLUSH: begin
                    if (cnt == '0) begin
                        flush_o <= 1'b0;
                        if (HOLD_CYCLES == 0) begin
                            state  <= ST_IDLE;
                            busy_o <= 1'b0;
                        end else begin
                            state <= ST_HOLD;
                            cnt   <= CNT_W'(HOLD_CYCLES - 1);
                        end
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                ST_HOLD: begin
                    if (cnt == '0) begin
                        state  <= ST_IDLE;
                        busy_o <= 1'b0;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end

`ifdef EXC_STATS_EN
    logic [STAT_W-1:0] exc_count_q;

    // Saturating count of accepted exceptions.
    always_ff @(posedge clk) begin
        if (rst) begin
            exc_count_q <= '0;
        end else if (accept && (exc_count_q != 16'hFFFF)) begin
            exc_count_q <= exc_count_q + STAT_W'(1);
        end
    end

    assign exc_count_o = exc_count_q;
`else
    assign exc_count_o = 16'h0000;
`endif

endmodule

// File: tb/tb_exc_ctrl_seq.sv
// Directed scoreboard bench for exc_ctrl_seq with default parameters.
module tb_exc_ctrl_seq;

    typedef enum int {
        S_STALL, S_FLUSH, S_NPC, S_NPCV, S_CTYPE, S_CPC, S_CDS, S_BUSY, S_CNT
    } sig_e;

    typedef struct {
        int unsigned cyc;
        sig_e        sel;
        logic [31:0] val;
    } exp_t;

`ifdef EXC_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic [31:0] except_type_i;
    logic [31:0] except_pc_i;
    logic        is_in_delayslot_i;
    logic [31:0] cp0_epc_i;
    logic        stallreq_id_i;
    logic        stallreq_ex_i;
    logic [5:0]  stall_o;
    logic        flush_o;
    logic [31:0] new_pc_o;
    logic        new_pc_valid_o;
    logic [31:0] cp0_except_type_o;
    logic [31:0] cp0_except_pc_o;
    logic        cp0_delayslot_o;
    logic        busy_o;
    logic [15:0] exc_count_o;

    exp_t        sb[$];
    int unsigned cyc;
    int          checks;
    int          errors;

    exc_ctrl_seq dut (
        .clk               (clk),
        .rst               (rst),
        .except_type_i     (except_type_i),
        .except_pc_i       (except_pc_i),
        .is_in_delayslot_i (is_in_delayslot_i),
        .cp0_epc_i         (cp0_epc_i),
        .stallreq_id_i     (stallreq_id_i),
        .stallreq_ex_i     (stallreq_ex_i),
        .stall_o           (stall_o),
        .flush_o           (flush_o),
        .new_pc_o          (new_pc_o),
        .new_pc_valid_o    (new_pc_valid_o),
        .cp0_except_type_o (cp0_except_type_o),
        .cp0_except_pc_o   (cp0_except_pc_o),
        .cp0_delayslot_o   (cp0_delayslot_o),
        .busy_o            (busy_o),
        .exc_count_o       (exc_count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] obs(input sig_e s);
        case (s)
            S_STALL: return 32'(stall_o);
            S_FLUSH: return 32'(flush_o);
            S_NPC:   return new_pc_o;
            S_NPCV:  return 32'(new_pc_valid_o);
            S_CTYPE: return cp0_except_type_o;
            S_CPC:   return cp0_except_pc_o;
            S_CDS:   return 32'(cp0_delayslot_o);
            S_BUSY:  return 32'(busy_o);
            S_CNT:   return 32'(exc_count_o);
            default: return 32'hxxxx_xxxx;
        endcase
    endfunction

    function automatic logic [31:0] cntv(input int n);
        return STATS ? 32'(n) : 32'h0;
    endfunction

    task automatic push(input int unsigned c, input sig_e s, input logic [31:0] v);
        exp_t e;
        e.cyc = c;
        e.sel = s;
        e.val = v;
        sb.push_back(e);
    endtask

    // Compare every scoreboard entry due this cycle, then advance one clock.
    task automatic run_cycle();
        logic [31:0] o;
        #1;
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc == cyc) begin
                o = obs(sb[i].sel);
                checks++;
                assert (o === sb[i].val) else begin
                    errors++;
                    $error("FAIL %s cyc=%0d observed=%h expected=%h",
                           sb[i].sel.name(), cyc, o, sb[i].val);
                end
                sb.delete(i);
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Expected trace of one accepted exception, accept cycle t.
    task automatic expect_seq(input int unsigned t, input logic [31:0] typ,
                              input logic [31:0] pc, input logic ds,
                              input logic [31:0] tgt);
        push(t,     S_STALL, 32'h3f);
        push(t,     S_BUSY,  32'h0);
        push(t + 1, S_CTYPE, typ);
        push(t + 1, S_CPC,   pc);
        push(t + 1, S_CDS,   32'(ds));
        push(t + 1, S_STALL, 32'h3f);
        push(t + 1, S_BUSY,  32'h1);
        push(t + 1, S_FLUSH, 32'h0);
        push(t + 2, S_FLUSH, 32'h1);
        push(t + 2, S_NPC,   tgt);
        push(t + 2, S_NPCV,  32'h1);
        push(t + 2, S_CTYPE, 32'h0);
        push(t + 2, S_STALL, 32'h0);
        push(t + 2, S_BUSY,  32'h1);
        push(t + 3, S_FLUSH, 32'h0);
        push(t + 3, S_NPCV,  32'h0);
        push(t + 3, S_NPC,   tgt);
        push(t + 3, S_BUSY,  32'h1);
        push(t + 4, S_BUSY,  32'h1);
        push(t + 4, S_FLUSH, 32'h0);
        push(t + 5, S_BUSY,  32'h0);
    endtask

    initial begin
        int unsigned t;
        int unsigned t2;
        cyc = 0;
        checks = 0;
        errors = 0;
        rst = 1'b1;
        except_type_i = 32'h0;
        except_pc_i = 32'h0;
        is_in_delayslot_i = 1'b0;
        cp0_epc_i = 32'h0;
        stallreq_id_i = 1'b0;
        stallreq_ex_i = 1'b0;
        @(posedge clk);
        #1;
        run_cycle();
        run_cycle();
        rst = 1'b0;

        // Reset state.
        push(cyc, S_STALL, 32'h0);
        push(cyc, S_FLUSH, 32'h0);
        push(cyc, S_NPC,   32'h0);
        push(cyc, S_NPCV,  32'h0);
        push(cyc, S_CTYPE, 32'h0);
        push(cyc, S_CPC,   32'h0);
        push(cyc, S_CDS,   32'h0);
        push(cyc, S_BUSY,  32'h0);
        push(cyc, S_CNT,   32'h0);
        run_cycle();

        // Syscall: sequence length and single CP0 commit; inputs change after accept.
        t = cyc;
        except_type_i = 32'h8;
        except_pc_i = 32'h100;
        is_in_delayslot_i = 1'b0;
        cp0_epc_i = 32'hdead_beef;
        expect_seq(t, 32'h8, 32'h100, 1'b0, 32'h20);
        push(t + 3, S_CPC, 32'h100);
        push(t + 5, S_STALL, 32'h0);
        run_cycle();
        except_type_i = 32'h0;
        except_pc_i = 32'h999;
        is_in_delayslot_i = 1'b1;
        repeat (5) run_cycle();

        // ERET redirects to the EPC sampled at accept.
        t = cyc;
        except_type_i = 32'he;
        except_pc_i = 32'h300;
        is_in_delayslot_i = 1'b0;
        cp0_epc_i = 32'h1234;
        expect_seq(t, 32'he, 32'h300, 1'b0, 32'h1234);
        run_cycle();
        except_type_i = 32'h0;
        cp0_epc_i = 32'h5555;
        repeat (5) run_cycle();

        // Interrupt in delay slot; second code masked during HOLD, accepted on return to IDLE.
        t = cyc;
        except_type_i = 32'h1;
        except_pc_i = 32'h204;
        is_in_delayslot_i = 1'b1;
        expect_seq(t, 32'h1, 32'h204, 1'b1, 32'h20);
        run_cycle();
        except_type_i = 32'h0;
        run_cycle();
        run_cycle();
        except_type_i = 32'hc;
        except_pc_i = 32'h400;
        is_in_delayslot_i = 1'b0;
        push(t + 3, S_STALL, 32'h0);
        push(t + 4, S_STALL, 32'h0);
        push(t + 4, S_CTYPE, 32'h0);
        run_cycle();
        run_cycle();
        t2 = cyc;
        expect_seq(t2, 32'hc, 32'h400, 1'b0, 32'h20);
        run_cycle();
        except_type_i = 32'h0;
        repeat (5) run_cycle();

        // Stall merge and exception priority over stall requests.
        stallreq_id_i = 1'b1;
        stallreq_ex_i = 1'b1;
        push(cyc, S_STALL, 32'h0f);
        push(cyc, S_BUSY,  32'h0);
        run_cycle();
        stallreq_ex_i = 1'b0;
        push(cyc, S_STALL, 32'h07);
        run_cycle();
        stallreq_ex_i = 1'b1;
        except_type_i = 32'ha;
        except_pc_i = 32'h500;
        t = cyc;
        expect_seq(t, 32'ha, 32'h500, 1'b0, 32'h20);
        run_cycle();
        stallreq_id_i = 1'b0;
        stallreq_ex_i = 1'b0;
        except_type_i = 32'h0;
        run_cycle();
        run_cycle();
        stallreq_id_i = 1'b1;
        push(cyc, S_STALL, 32'h07);
        run_cycle();
        stallreq_id_i = 1'b0;
        push(cyc, S_STALL, 32'h0);
        run_cycle();
        run_cycle();

        // Unknown code is ignored.
        except_type_i = 32'h5;
        push(cyc, S_STALL, 32'h0);
        push(cyc, S_BUSY,  32'h0);
        run_cycle();
        except_type_i = 32'h0;
        push(cyc, S_BUSY,  32'h0);
        push(cyc, S_FLUSH, 32'h0);
        push(cyc, S_CTYPE, 32'h0);
        push(cyc, S_CNT,   cntv(5));
        run_cycle();

        // Reset during FREEZE aborts the sequence.
        t = cyc;
        except_type_i = 32'hd;
        except_pc_i = 32'h600;
        is_in_delayslot_i = 1'b1;
        push(t,     S_STALL, 32'h3f);
        push(t + 1, S_CTYPE, 32'hd);
        push(t + 1, S_CDS,   32'h1);
        push(t + 1, S_BUSY,  32'h1);
        run_cycle();
        rst = 1'b1;
        except_type_i = 32'h0;
        is_in_delayslot_i = 1'b0;
        run_cycle();
        rst = 1'b0;
        push(cyc, S_STALL, 32'h0);
        push(cyc, S_FLUSH, 32'h0);
        push(cyc, S_NPC,   32'h0);
        push(cyc, S_NPCV,  32'h0);
        push(cyc, S_CTYPE, 32'h0);
        push(cyc, S_CPC,   32'h0);
        push(cyc, S_CDS,   32'h0);
        push(cyc, S_BUSY,  32'h0);
        push(cyc, S_CNT,   32'h0);
        run_cycle();
        push(cyc, S_FLUSH, 32'h0);
        push(cyc, S_BUSY,  32'h0);
        push(cyc, S_NPCV,  32'h0);
        run_cycle();
        push(cyc, S_FLUSH, 32'h0);
        run_cycle();

        // Held syscall is accepted every five cycles; counter tracks accepts.
        t = cyc;
        except_type_i = 32'h8;
        except_pc_i = 32'h700;
        expect_seq(t,      32'h8, 32'h700, 1'b0, 32'h20);
        expect_seq(t + 5,  32'h8, 32'h700, 1'b0, 32'h20);
        expect_seq(t + 10, 32'h8, 32'h700, 1'b0, 32'h20);
        push(t + 1,  S_CNT, cntv(1));
        push(t + 6,  S_CNT, cntv(2));
        push(t + 11, S_CNT, cntv(3));
        push(t + 15, S_CNT, cntv(3));
        repeat (11) run_cycle();
        except_type_i = 32'h0;
        repeat (7) run_cycle();

        // Anything still queued was never compared.
        for (int i = 0; i < sb.size(); i++) begin
            checks++;
            errors++;
            $display("FAIL %s pending cyc=%0d expected=%h", sb[i].sel.name(), sb[i].cyc, sb[i].val);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
